alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu4_core.sv | 49 ++++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 5;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_PASS = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 3'd3;
    localparam logic [OP_W-1:0] OP_MOD  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] OP_GT   = 3'd7;

    localparam logic [RES_W-1:0] DIV0_RESULT = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU producing a 5-bit result and a divide-by-zero flag.
module alu4_core
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OP_W-1:0]   sel,
    output logic [RES_W-1:0]  result,
    output logic              err
);

    logic [RES_W-1:0] a_x_s;
    logic [RES_W-1:0] b_x_s;

    assign a_x_s = {1'b0, a};
    assign b_x_s = {1'b0, b};

    // Opcode decode; subtraction wraps modulo 32 through the 5-bit datapath.
    always_comb begin
        result = {RES_W{1'b0}};
        err    = 1'b0;
        case (sel)
            OP_PASS: result = a_x_s;
            OP_ADD:  result = a_x_s + b_x_s;
            OP_SUB:  result = a_x_s - b_x_s;
            OP_DIV: begin
                if (b == 4'd0) begin
                    result = DIV0_RESULT;
                    err    = 1'b1;
                end else begin
                    result = {1'b0, a / b};
                end
            end
            OP_MOD: begin
                if (b == 4'd0) begin
                    result = DIV0_RESULT;
                    err    = 1'b1;
                end else begin
                    result = {1'b0, a % b};
                end
            end
            OP_SHL:  result = {a, 1'b0};
            OP_SHR:  result = {2'b00, a[3:1]};
            OP_GT:   result = {4'b0000, (a > b)};
            default: result = {RES_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU through an IDLE/EXEC/RESP pipeline
// with a registered, backpressured response port and a completion counter.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_err,
    output logic [7:0]        ops_done
);

    state_e            state_q;
    state_e            state_d;
    logic              prio_q;
    logic [OPND_W-1:0] a_q;
    logic [OPND_W-1:0] b_q;
    logic [OP_W-1:0]   sel_q;
    logic              id_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [RES_W-1:0]  rsp_result_q;
    logic              rsp_err_q;
    logic [7:0]        ops_q;

    logic              grant_vld_s;
    logic              grant_id_s;
    logic              idle_s;
    logic              accept_s;
    logic              rsp_hs_s;
    logic [RES_W-1:0]  core_result_s;
    logic              core_err_s;

    // Grant selection: prio_q names the requester that wins a tie.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = prio_q;
        end else if (req0_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b0;
        end else if (req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    assign idle_s     = (state_q == ST_IDLE) && !rst;
    assign accept_s   = idle_s && grant_vld_s;
    assign req0_ready = accept_s && !grant_id_s;
    assign req1_ready = accept_s && grant_id_s;
    assign rsp_hs_s   = rsp_valid_q && rsp_ready;

    // Next-state logic for the single-operation pipeline.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu4_core u_core (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (core_result_s),
        .err    (core_err_s)
    );

    // State, capture, response and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            sel_q        <= 3'd0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 5'd0;
            rsp_err_q    <= 1'b0;
            ops_q        <= 8'd0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                a_q    <= grant_id_s ? req1_a   : req0_a;
                b_q    <= grant_id_s ? req1_b   : req0_b;
                sel_q  <= grant_id_s ? req1_sel : req0_sel;
                id_q   <= grant_id_s;
                prio_q <= ~grant_id_s;
            end
            // Response fields change only when a fresh result lands, so they hold under backpressure.
            if (state_q == ST_EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= id_q;
                rsp_result_q <= core_result_s;
                rsp_err_q    <= core_err_s;
            end else if (rsp_hs_s) begin
                rsp_valid_q  <= 1'b0;
            end
            if (rsp_hs_s) begin
                ops_q <= ops_q + 8'd1;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign ops_done   = ops_q;

endmodule
